// File: rtl/mmio_pkg.sv
// Shared types and the default memory map for the RV32I data-bus interconnect.
package mmio_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  // Current map, index 0 first: ROM, CLINT, PLIC, UART, SEG7, RAM
  localparam int unsigned MAP_N_SLV = 6;

  localparam logic [MAP_N_SLV-1:0][31:0] MAP_BASE = {
    32'h8000_0000, 32'h2000_0000, 32'h1000_0000,
    32'h0C00_0000, 32'h0200_0000, 32'h0000_0000
  };

  localparam logic [MAP_N_SLV-1:0][31:0] MAP_MASK = {
    32'h8000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF0,
    32'hFC00_0000, 32'hFE00_0000, 32'hFE00_0000
  };

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational base/mask address decoder: lowest matching index wins,
// otherwise the optional catch-all slave is selected.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int unsigned                N_SLV       = MAP_N_SLV,
  parameter logic [N_SLV-1:0][31:0]     BASE_ADDR   = MAP_BASE,
  parameter logic [N_SLV-1:0][31:0]     ADDR_MASK   = MAP_MASK,
  parameter int unsigned                DEFAULT_SLV = N_SLV,
  localparam int unsigned               IDX_W       = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
  input  addr_t             addr,
  output logic [N_SLV-1:0]  match,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output addr_t             offset
);

  // Clamped so the catch-all branch never indexes past the map when disabled
  localparam bit          HAS_DEF = (DEFAULT_SLV < N_SLV);
  localparam int unsigned DEF_IDX = HAS_DEF ? DEFAULT_SLV : 0;

  always_comb begin
    match  = '0;
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (!hit && ((addr & ADDR_MASK[i]) == BASE_ADDR[i])) begin
        hit      = 1'b1;
        idx      = IDX_W'(i);
        match[i] = 1'b1;
        offset   = addr & ~ADDR_MASK[i];
      end
    end
    if (!hit && HAS_DEF) begin
      hit            = 1'b1;
      idx            = IDX_W'(DEF_IDX);
      match[DEF_IDX] = 1'b1;
      offset         = addr & ~ADDR_MASK[DEF_IDX];
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Single-master, N-slave MMIO interconnect with valid/ready toward the core,
// per-slave ready, and bus-error responses for unmapped addresses and timeouts.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int unsigned            N_SLV       = MAP_N_SLV,
  parameter logic [N_SLV-1:0][31:0] BASE_ADDR   = MAP_BASE,
  parameter logic [N_SLV-1:0][31:0] ADDR_MASK   = MAP_MASK,
  parameter int unsigned            DEFAULT_SLV = N_SLV,
  parameter int unsigned            TIMEOUT     = 255
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               m_req_valid,
  output logic               m_req_ready,
  input  logic [31:0]        m_addr,
  input  logic [3:0]         m_we,
  input  logic [31:0]        m_wdata,
  output logic               m_rsp_valid,
  output logic [31:0]        m_rdata,
  output logic               m_err,
  output logic [31:0]        err_addr,
  output logic [N_SLV-1:0]   s_cs,
  output logic [31:0]        s_addr,
  output logic [3:0]         s_we,
  output logic [31:0]        s_wdata,
  input  logic [N_SLV*32-1:0] s_rdata,
  input  logic [N_SLV-1:0]   s_ready
);

  localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  state_t             state, state_nx;
  logic [N_SLV-1:0]   dec_match, cs_q;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx, idx_q;
  addr_t              dec_offset, offset_q, addr_q, err_addr_q;
  logic [3:0]         we_q;
  data_t              wdata_q, rdata_q, sel_rdata;
  logic               err_q, sel_ready;
  logic [15:0]        cnt_q;
  logic               accept, done_ok, done_to, cnt_inc;

  mmio_addr_decode #(
    .N_SLV       (N_SLV),
    .BASE_ADDR   (BASE_ADDR),
    .ADDR_MASK   (ADDR_MASK),
    .DEFAULT_SLV (DEFAULT_SLV)
  ) u_decode (
    .addr   (m_addr),
    .match  (dec_match),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (m_req_valid) begin
          accept   = 1'b1;
          state_nx = dec_hit ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        // Ready takes priority over the timeout on the final allowed cycle
        if (sel_ready) begin
          done_ok  = 1'b1;
          state_nx = RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          done_to  = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      addr_q     <= '0;
      offset_q   <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      cs_q       <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= m_addr;
        offset_q <= dec_offset;
        we_q     <= m_we;
        wdata_q  <= m_wdata;
        cs_q     <= dec_match;
        idx_q    <= dec_idx;
        cnt_q    <= '0;
        if (!dec_hit) begin
          rdata_q    <= '0;
          err_q      <= 1'b1;
          err_addr_q <= m_addr;
        end
      end
      if (cnt_inc) cnt_q <= cnt_q + 16'd1;
      if (done_ok) begin
        rdata_q <= (we_q == '0) ? sel_rdata : '0;
        err_q   <= 1'b0;
      end
      if (done_to) begin
        rdata_q    <= '0;
        err_q      <= 1'b1;
        err_addr_q <= addr_q;
      end
    end
  end

  assign m_req_ready = (state == IDLE);
  assign m_rsp_valid = (state == RESP);
  assign m_rdata     = rdata_q;
  assign m_err       = err_q;
  assign err_addr    = err_addr_q;
  assign s_cs        = (state == ACCESS) ? cs_q : '0;
  assign s_addr      = offset_q;
  assign s_we        = (state == ACCESS) ? we_q : '0;
  assign s_wdata     = wdata_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Scoreboard bench for mmio_interconnect: directed requests push expected
// responses; a monitor checks slave-side signals and every response.
module tb_mmio_interconnect;

  localparam int unsigned N   = 6;
  localparam int unsigned TMO = 4;
  // Slave 2 is remapped over the bottom of slave 0 to exercise priority
  localparam logic [N-1:0][31:0] TB_BASE = {
    32'h8000_0000, 32'h2000_0000, 32'h1000_0000,
    32'h0000_0000, 32'h0200_0000, 32'h0000_0000
  };
  localparam logic [N-1:0][31:0] TB_MASK = {
    32'h8000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF0,
    32'hFFFF_0000, 32'hFE00_0000, 32'hFE00_0000
  };

  logic               clk_in = 1'b0;
  logic               rst_n;
  logic               m_req_valid, m_req_ready;
  logic [31:0]        m_addr, m_wdata, m_rdata, err_addr, s_addr, s_wdata;
  logic [3:0]         m_we, s_we;
  logic               m_rsp_valid, m_err;
  logic [N-1:0]       s_cs;
  logic [N*32-1:0]    s_rdata;
  logic [N-1:0]       s_ready = '0;

  mmio_interconnect #(
    .N_SLV       (N),
    .BASE_ADDR   (TB_BASE),
    .ADDR_MASK   (TB_MASK),
    .DEFAULT_SLV (N),
    .TIMEOUT     (TMO)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_addr      (m_addr),
    .m_we        (m_we),
    .m_wdata     (m_wdata),
    .m_rsp_valid (m_rsp_valid),
    .m_rdata     (m_rdata),
    .m_err       (m_err),
    .err_addr    (err_addr),
    .s_cs        (s_cs),
    .s_addr      (s_addr),
    .s_we        (s_we),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    int          acc;
    int          lat;
    int          cscyc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] eaddr;
    logic [31:0] saddr;
    logic [31:0] wdata;
    logic [N-1:0] cs;
    logic [3:0]  we;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          slv_wait = 0;
  int          cs_cnt  = 0;
  int          cs_cyc  = 0;
  int          commits = 0;
  logic [31:0] last_eaddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Slave model: selected slave is ready after slv_wait wait cycles
  // (never when negative); every non-selected slave always claims ready.
  always @(posedge clk_in) begin
    #1;
    if (s_cs != '0) begin
      s_ready = ((slv_wait >= 0) && (cs_cnt == slv_wait)) ? s_cs : '0;
      s_ready = s_ready | ~s_cs;
      cs_cnt++;
    end else begin
      cs_cnt  = 0;
      s_ready = '1;
    end
  end

  always @(negedge clk_in) begin
    if (!rst_n) begin
      cs_cyc  = 0;
      commits = 0;
    end else begin
      if (s_cs != '0) begin
        if (q.size() == 0) chk("cs_without_txn", 32'(s_cs), 32'h0);
        else begin
          chk("s_cs",    32'(s_cs), 32'(q[0].cs));
          chk("s_addr",  s_addr,    q[0].saddr);
          chk("s_we",    32'(s_we), 32'(q[0].we));
          chk("s_wdata", s_wdata,   q[0].wdata);
        end
        cs_cyc++;
        if ((s_cs & s_ready) != '0) commits++;
      end
      if (m_rsp_valid) begin
        if (q.size() == 0) chk("spurious_rsp", 32'h1, 32'h0);
        else begin
          e = q.pop_front();
          chk("latency",   32'(cyc - e.acc), 32'(e.lat));
          chk("m_err",     32'(m_err), 32'(e.err));
          chk("m_rdata",   m_rdata, e.rdata);
          chk("err_addr",  err_addr, e.eaddr);
          chk("cs_cycles", 32'(cs_cyc), 32'(e.cscyc));
          chk("commits",   32'(commits), e.err ? 32'h0 : 32'h1);
        end
        cs_cyc  = 0;
        commits = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                       input logic [N-1:0] cs, input logic [31:0] saddr, input logic err,
                       input logic [31:0] rdata, input int lat, input int cscyc, output int acc);
    exp_t x;
    logic rdy;
    bit   ok = 1'b0;
    @(negedge clk_in);
    m_addr = addr; m_we = we; m_wdata = wdata; m_req_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rdy = m_req_ready;
      @(posedge clk_in);
      if (rdy) begin ok = 1'b1; break; end
      @(negedge clk_in);
    end
    #1;
    acc = cyc;
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    else begin
      if (err) last_eaddr = addr;
      x.acc = cyc; x.lat = lat; x.cscyc = cscyc; x.err = err; x.rdata = rdata;
      x.eaddr = last_eaddr; x.saddr = saddr; x.wdata = wdata; x.cs = cs; x.we = we;
      q.push_back(x);
    end
    m_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_in);
      if (q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      chk("rsp_timeout", 32'(q.size()), 32'h0);
      q.delete();
    end
    @(posedge clk_in);
  endtask

  initial begin
    int acc_a, acc_b;
    rst_n = 1'b0; m_req_valid = 1'b0; m_addr = '0; m_we = '0; m_wdata = '0;
    for (int i = 0; i < int'(N); i++) s_rdata[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_req_ready", 32'(m_req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'h0);
    chk("rst_rdata",     m_rdata,          32'h0);
    chk("rst_err",       32'(m_err),       32'h0);
    chk("rst_err_addr",  err_addr,         32'h0);
    chk("rst_s_cs",      32'(s_cs),        32'h0);
    chk("rst_s_addr",    s_addr,           32'h0);
    chk("rst_s_we",      32'(s_we),        32'h0);
    chk("rst_s_wdata",   s_wdata,          32'h0);
    @(posedge clk_in); #2 rst_n = 1'b1;

    // UART read, zero wait
    slv_wait = 0; s_rdata[3*32 +: 32] = 32'h0000_0041;
    issue(32'h1000_0004, 4'b0000, 32'h0, 6'b001000, 32'h4, 1'b0, 32'h41, 1, 1, acc_a);
    wait_idle();
    repeat (2) @(negedge clk_in);
    chk("rdata_hold", m_rdata, 32'h41);
    chk("err_hold",   32'(m_err), 32'h0);

    // RAM write, 3 wait cycles
    slv_wait = 3;
    issue(32'h8000_0010, 4'b0011, 32'hDEAD_BEEF, 6'b100000, 32'h10, 1'b0, 32'h0, 4, 4, acc_a);
    wait_idle();

    // Unmapped read
    issue(32'h4000_0000, 4'b0000, 32'h0, 6'b000000, 32'h0, 1'b1, 32'h0, 0, 0, acc_a);
    wait_idle();
    @(negedge clk_in);
    chk("err_hold_unmapped", 32'(m_err), 32'h1);

    // Slave never ready: timeout after TMO select cycles
    slv_wait = -1;
    issue(32'h2000_0002, 4'b0000, 32'h0, 6'b010000, 32'h2, 1'b1, 32'h0, TMO, TMO, acc_a);
    wait_idle();

    // Ready on the last allowed cycle wins over timeout
    slv_wait = 3; s_rdata[1*32 +: 32] = 32'h1234_5678;
    issue(32'h0200_0100, 4'b0000, 32'h0, 6'b000010, 32'h100, 1'b0, 32'h1234_5678, 4, 4, acc_a);
    wait_idle();

    // Overlap of slaves 0 and 2: lowest index wins
    slv_wait = 0; s_rdata[0 +: 32] = 32'hAAAA_5555; s_rdata[2*32 +: 32] = 32'h0000_BBBB;
    issue(32'h0000_0100, 4'b0000, 32'h0, 6'b000001, 32'h100, 1'b0, 32'hAAAA_5555, 1, 1, acc_a);
    wait_idle();

    // Back-to-back: second request held by core until IDLE
    issue(32'h1000_0000, 4'b0000, 32'h0, 6'b001000, 32'h0, 1'b0, 32'h41, 1, 1, acc_a);
    issue(32'h1000_000C, 4'b1111, 32'h0BAD_F00D, 6'b001000, 32'hC, 1'b0, 32'h0, 1, 1, acc_b);
    chk("b2b_spacing", 32'(acc_b - acc_a), 32'h3);
    wait_idle();

    // Reset asserted mid-ACCESS
    slv_wait = -1;
    issue(32'h1000_0008, 4'b0000, 32'h0, 6'b001000, 32'h8, 1'b0, 32'h0, 1, 1, acc_a);
    @(posedge clk_in); #2 rst_n = 1'b0;
    @(posedge clk_in); #2;
    q.delete(); rst_n = 1'b1; last_eaddr = '0;
    @(negedge clk_in);
    chk("abort_s_cs",      32'(s_cs),        32'h0);
    chk("abort_rsp_valid", 32'(m_rsp_valid), 32'h0);
    chk("abort_req_ready", 32'(m_req_ready), 32'h1);
    chk("abort_err_addr",  err_addr,         32'h0);
    repeat (3) @(negedge clk_in);

    // Normal read after reset, one wait cycle
    slv_wait = 1; s_rdata[3*32 +: 32] = 32'h0000_0099;
    issue(32'h1000_0008, 4'b0000, 32'h0, 6'b001000, 32'h8, 1'b0, 32'h99, 2, 2, acc_a);
    wait_idle();
    repeat (2) @(posedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
